markov_transition_learner: RTL
==============================

Name: markov_transition_learner

Overview:
- Parametrised successor to the single-shot Markov learner FSM.
- Learns first-order transitions (prev symbol -> next symbol) from a symbol stream into a DEPTH-entry transition list. Each list entry holds {prev, next, count}.
- Sequential scan per symbol: an existing transition increments its count; a new transition is appended.
- Sits between the note/symbol source and the sequence generator. The generator reads the table back through a registered read port.

Parameters:
SYM_W, 4, symbol width in bits
DEPTH, 16, maximum number of transition entries
CNT_W, 8, per-entry count width (saturating)
IDX_W, $clog2(DEPTH+1), width of index and entry-count ports

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin a learning session (clears table)
sym_valid  in  1  input symbol valid
sym_data  in  SYM_W  input symbol
sym_last  in  1  marks final symbol of session
sym_ready  out  1  learner can accept a symbol this cycle
rd_idx  in  IDX_W  readback entry index
rd_prev  out  SYM_W  entry prev symbol (registered)
rd_next  out  SYM_W  entry next symbol (registered)
rd_count  out  CNT_W  entry count (registered)
entries  out  IDX_W  number of valid entries
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at session end
overflow  out  1  sticky: a new transition was dropped because the table was full
sat  out  1  sticky: an increment hit the maximum count

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high on reset.
- Reset values: state=IDLE; sym_ready, busy, done, overflow and sat =0; entries=0; rd_* =0; has_prev=0.
- A reset mid-session aborts it immediately and the table is lost.
- IDLE:
  - sym_ready=0.
  - start -> INIT. Otherwise stay.
  - Table is retained and readable.
- INIT (1 cycle):
  - entries<=0, has_prev<=0, overflow<=0, sat<=0.
  - -> WAIT.
- WAIT:
  - sym_ready=1. A handshake is sym_valid&sym_ready. Capture cur<=sym_data and last_q<=sym_last.
  - If !has_prev: prev<=sym_data, has_prev<=1, then -> FINISH if sym_last, else stay in WAIT.
  - If has_prev: i<=0, -> CHECK.
  - start is ignored outside IDLE/FINISH.
- CHECK (one entry per cycle):
  - If i==entries -> ADD.
  - Else if entry[i].prev==prev and entry[i].next==cur -> INC.
  - Else i<=i+1.
- INC:
  - If count[i]==2^CNT_W-1, hold the value and set sat<=1. Else count[i]<=count[i]+1.
  - prev<=cur.
  - -> FINISH if last_q, else -> WAIT.
- ADD:
  - If entries<DEPTH: write {prev,cur,1} at index entries; entries<=entries+1.
  - Else: drop the transition and set overflow<=1.
  - prev<=cur.
  - -> FINISH if last_q, else -> WAIT.
- FINISH (1 cycle):
  - done=1.
  - start in this cycle -> INIT. Else -> IDLE.
- Per-symbol latency:
  - Match at index k: 1 (WAIT) + k+1 (CHECK) + 1 (INC) cycles.
  - No match: 1 + entries+1 + 1 cycles.
  - The next symbol is accepted only after returning to WAIT.
- Readback:
  - rd_* update one cycle after rd_idx.
  - Valid in any state; reflects table contents as of the prior cycle.
  - rd_idx>=entries returns all zeros.
- Single-symbol session (first symbol has sym_last): FINISH with entries=0.
- Self-transitions (prev==cur) are legal entries.
- A symbol with sym_valid=1 held while busy scanning is not consumed (sym_ready=0).

Optional Feature:
- Macro MARKOV_ROW_TOTAL_EN.
- Defined:
  - Adds per-prev-symbol row totals: 2^SYM_W registers of width CNT_W+$clog2(DEPTH+1).
  - Adds ports rd_row_sym (in, SYM_W) and rd_row_total (out, total width, registered 1 cycle).
  - A row total increments by 1 in INC (only when the count is not saturated) and in ADD (only when the entry is written).
  - Row totals are cleared in INIT and on reset.
- Undefined: no row-total storage and no extra ports; all other behaviour is identical.

Decomposition:
- Shared definitions in defines.v:
  - state encodings (IDLE, INIT, WAIT, CHECK, INC, ADD, FINISH);
  - entry field widths;
  - count max constant.
- Sub-module markov_entry_ram:
  - DEPTH-entry register file with one write port (data, or count-only increment).
  - One combinational scan read port (index i).
  - One registered readback port (rd_idx).
  - Entries at index >= entries masked to zero.

Test Plan:
- Sequence A,B,A,B (last on the 4th): entries=2, {A,B,2}, {B,A,1}, done pulses once, overflow=0.
- Single symbol 5 with sym_last: done one cycle after WAIT handshake, entries=0.
- DEPTH=4, sequence 0,1,2,3,4,5,6 (6 distinct transitions): entries=4, overflow=1, rd_idx 4 returns zeros.
- CNT_W=2, sequence 3,3,3,3,3,3: entry {3,3} count saturates at 3, sat=1.
- Reset asserted during CHECK: next cycle state=IDLE, entries=0, busy=0, done=0.
- MARKOV_ROW_TOTAL_EN with A,B,A,C,A,B: rd_row_total(A)=3, rd_row_total(B)=1, rd_row_total(C)=1.

Source files
------------

// File: rtl/markov_transition_learner_pkg.sv
// Shared definitions for the Markov transition learner: FSM state encoding
// and the saturating-count limit helper. The optional row-total feature is
// selected in the top with the macro MARKOV_ROW_TOTAL_EN.
package markov_transition_learner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_WAIT,
        ST_CHECK,
        ST_INC,
        ST_ADD,
        ST_FINISH
    } state_e;

    // All-ones value of a width-bit counter (widths up to 32).
    function automatic int unsigned sat_max(input int unsigned width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/markov_entry_ram.sv
// Transition list storage: DEPTH entries of {prev, next, count}.
// One write port (full entry or count-only increment), one combinational
// scan port and one registered readback port. Entries at or beyond the live
// entry count read as zero on both read ports.
module markov_entry_ram
    import markov_transition_learner_pkg::*;
#(
    parameter int SYM_W = 4,
    parameter int DEPTH = 16,
    parameter int CNT_W = 8,
    parameter int IDX_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] entries,
    input  logic             wr_en,
    input  logic             inc_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [SYM_W-1:0] wr_prev,
    input  logic [SYM_W-1:0] wr_next,
    input  logic [IDX_W-1:0] scan_idx,
    output logic [SYM_W-1:0] scan_prev,
    output logic [SYM_W-1:0] scan_next,
    output logic [CNT_W-1:0] scan_count,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [SYM_W-1:0] rd_prev,
    output logic [SYM_W-1:0] rd_next,
    output logic [CNT_W-1:0] rd_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);

    logic [SYM_W-1:0] mem_prev_q [DEPTH];
    logic [SYM_W-1:0] mem_next_q [DEPTH];
    logic [CNT_W-1:0] mem_cnt_q  [DEPTH];

    logic [AW-1:0]    wr_slot;
    logic             wr_in_range;
    logic [CNT_W-1:0] wr_count_d;
    logic [SYM_W-1:0] rd_prev_d, rd_prev_q;
    logic [SYM_W-1:0] rd_next_d, rd_next_q;
    logic [CNT_W-1:0] rd_count_d, rd_count_q;

    assign wr_slot     = wr_idx[AW-1:0];
    assign wr_in_range = wr_idx < DEPTH_I;

    // Count to store: 1 for a freshly created entry, otherwise the old count plus one.
    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        wr_count_d = mem_cnt_q[wr_slot] + CNT_W'(1);
        if (wr_en) begin
            wr_count_d = CNT_W'(1);
        end
    end

    // Entry storage: full entry write or count-only increment.
    // NOTE: storage is not reset; reads beyond the live entry count are masked to zero.
    always_ff @(posedge clk) begin
        if (wr_in_range && (wr_en || inc_en)) begin
            mem_cnt_q[wr_slot] <= wr_count_d;
            if (wr_en) begin
                mem_prev_q[wr_slot] <= wr_prev;
                mem_next_q[wr_slot] <= wr_next;
            end
        end
    end

    // Scan port: combinational view of entry scan_idx, zero beyond the live count.
    always_comb begin
        scan_prev  = '0;
        scan_next  = '0;
        scan_count = '0;
        if (scan_idx < entries) begin
            scan_prev  = mem_prev_q[scan_idx[AW-1:0]];
            scan_next  = mem_next_q[scan_idx[AW-1:0]];
            scan_count = mem_cnt_q[scan_idx[AW-1:0]];
        end
    end

    // Readback mux: entry rd_idx, zero beyond the live count.
    always_comb begin
        rd_prev_d  = '0;
        rd_next_d  = '0;
        rd_count_d = '0;
        if (rd_idx < entries) begin
            rd_prev_d  = mem_prev_q[rd_idx[AW-1:0]];
            rd_next_d  = mem_next_q[rd_idx[AW-1:0]];
            rd_count_d = mem_cnt_q[rd_idx[AW-1:0]];
        end
    end

    // Readback register: results appear one cycle after rd_idx.
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_prev_q  <= '0;
            rd_next_q  <= '0;
            rd_count_q <= '0;
        end else begin
            rd_prev_q  <= rd_prev_d;
            rd_next_q  <= rd_next_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_prev  = rd_prev_q;
    assign rd_next  = rd_next_q;
    assign rd_count = rd_count_q;

endmodule

// File: rtl/markov_transition_learner.sv
// First-order Markov transition learner. Each accepted symbol (after the
// first of a session) forms a transition prev->cur that is looked up by a
// sequential scan of the transition list: a hit bumps its saturating count,
// a miss appends a new entry or, when the list is full, sets overflow.
// Optional feature: define MARKOV_ROW_TOTAL_EN for per-prev-symbol row totals
// with a registered readback port (rd_row_sym / rd_row_total).
module markov_transition_learner
    import markov_transition_learner_pkg::*;
#(
    parameter int SYM_W = 4,
    parameter int DEPTH = 16,
    parameter int CNT_W = 8,
    parameter int IDX_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym_data,
    input  logic             sym_last,
    output logic             sym_ready,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [SYM_W-1:0] rd_prev,
    output logic [SYM_W-1:0] rd_next,
    output logic [CNT_W-1:0] rd_count,
    output logic [IDX_W-1:0] entries,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             sat
`ifdef MARKOV_ROW_TOTAL_EN
    ,
    input  logic [SYM_W-1:0]                     rd_row_sym,
    output logic [CNT_W+$clog2(DEPTH+1)-1:0]     rd_row_total
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
    localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);

    state_e           state_d, state_q;
    logic [IDX_W-1:0] entries_d, entries_q;
    logic [IDX_W-1:0] i_d, i_q;
    logic [SYM_W-1:0] prev_d, prev_q;
    logic [SYM_W-1:0] cur_d, cur_q;
    logic             has_prev_d, has_prev_q;
    logic             last_d, last_q;
    logic             overflow_d, overflow_q;
    logic             sat_d, sat_q;

    logic             wr_en;
    logic             inc_en;
    logic [SYM_W-1:0] scan_prev, scan_next;
    logic [CNT_W-1:0] scan_count;

    // Next-state and datapath control for the scan/update FSM.
    always_comb begin
        state_d    = state_q;
        entries_d  = entries_q;
        i_d        = i_q;
        prev_d     = prev_q;
        cur_d      = cur_q;
        has_prev_d = has_prev_q;
        last_d     = last_q;
        overflow_d = overflow_q;
        sat_d      = sat_q;
        wr_en      = 1'b0;
        inc_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_INIT;
            end
            ST_INIT: begin
                entries_d  = '0;
                has_prev_d = 1'b0;
                overflow_d = 1'b0;
                sat_d      = 1'b0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (sym_valid) begin
                    cur_d  = sym_data;
                    last_d = sym_last;
                    if (!has_prev_q) begin
                        prev_d     = sym_data;
                        has_prev_d = 1'b1;
                        state_d    = sym_last ? ST_FINISH : ST_WAIT;
                    end else begin
                        i_d     = '0;
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (i_q == entries_q) begin
                    state_d = ST_ADD;
                end else if (scan_prev == prev_q && scan_next == cur_q) begin
                    state_d = ST_INC;
                end else begin
                    i_d = i_q + IDX_W'(1);
                end
            end
            ST_INC: begin
                if (scan_count == CNT_MAX) begin
                    sat_d = 1'b1;
                end else begin
                    inc_en = 1'b1;
                end
                prev_d  = cur_q;
                state_d = last_q ? ST_FINISH : ST_WAIT;
            end
            ST_ADD: begin
                if (entries_q < DEPTH_I) begin
                    wr_en     = 1'b1;
                    entries_d = entries_q + IDX_W'(1);
                end else begin
                    overflow_d = 1'b1;
                end
                prev_d  = cur_q;
                state_d = last_q ? ST_FINISH : ST_WAIT;
            end
            ST_FINISH: begin
                state_d = start ? ST_INIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and session registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            entries_q  <= '0;
            i_q        <= '0;
            prev_q     <= '0;
            cur_q      <= '0;
            has_prev_q <= 1'b0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            entries_q  <= entries_d;
            i_q        <= i_d;
            prev_q     <= prev_d;
            cur_q      <= cur_d;
            has_prev_q <= has_prev_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
            sat_q      <= sat_d;
        end
    end

    // In ADD the scan index has stopped at entries_q, so i_q addresses both
    // the matched entry (INC) and the append slot (ADD).
    markov_entry_ram #(
        .SYM_W (SYM_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk        (clk),
        .reset      (reset),
        .entries    (entries_q),
        .wr_en      (wr_en),
        .inc_en     (inc_en),
        .wr_idx     (i_q),
        .wr_prev    (prev_q),
        .wr_next    (cur_q),
        .scan_idx   (i_q),
        .scan_prev  (scan_prev),
        .scan_next  (scan_next),
        .scan_count (scan_count),
        .rd_idx     (rd_idx),
        .rd_prev    (rd_prev),
        .rd_next    (rd_next),
        .rd_count   (rd_count)
    );

    assign sym_ready = (state_q == ST_WAIT);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FINISH);
    assign entries   = entries_q;
    assign overflow  = overflow_q;
    assign sat       = sat_q;

`ifdef MARKOV_ROW_TOTAL_EN
    localparam int ROW_W = CNT_W + $clog2(DEPTH + 1);
    localparam int ROWS  = 2 ** SYM_W;

    logic [ROW_W-1:0] row_total_q [ROWS];
    logic [ROW_W-1:0] row_sum_d;
    logic [ROW_W-1:0] rd_row_total_q;
    logic             row_inc;

    // A row grows exactly when an entry is created or its count actually increments.
    assign row_inc = wr_en | inc_en;

    // Incremented total for the row of the current prev symbol.
    always_comb begin
        row_sum_d = row_total_q[prev_q] + ROW_W'(1);
    end

    // Row total storage: cleared on reset and at session start.
    always_ff @(posedge clk) begin
        if (reset || state_q == ST_INIT) begin
            for (int r = 0; r < ROWS; r++) begin
                row_total_q[r] <= '0;
            end
        end else if (row_inc) begin
            row_total_q[prev_q] <= row_sum_d;
        end
    end

    // Registered row total readback.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_row_total_q <= '0;
        end else begin
            rd_row_total_q <= row_total_q[rd_row_sym];
        end
    end

    assign rd_row_total = rd_row_total_q;
`endif

endmodule
